// File: rtl/card_hand_datapath.sv
// card_hand_datapath: baccarat hand datapath with card source, six slots, scoring and deal count.
// Ports: slow_clock/resetb (async active-low), six load strobes, six slot ranks, pcard3,
// pscore/dscore (0..9), cards_dealt (saturating 0..6), sticky multi_load_err.
// Build option CARD_LFSR_SHUFFLE_EN replaces the 1..NUM_RANKS counter with a 16-bit Galois LFSR source.
module card_hand_datapath #(
  parameter int NUM_RANKS = 13,
  parameter int FACE_MIN  = 10
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1_out,
  output logic [3:0] pcard2_out,
  output logic [3:0] pcard3_out,
  output logic [3:0] dcard1_out,
  output logic [3:0] dcard2_out,
  output logic [3:0] dcard3_out,
  output logic [3:0] pcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] cards_dealt,
  output logic       multi_load_err
);
  localparam logic [3:0] NR = 4'(NUM_RANKS);
  localparam logic [3:0] FM = 4'(FACE_MIN);
  logic [3:0] rank;
  logic [3:0] p1_q, p2_q, p3_q, d1_q, d2_q, d3_q;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q;
  logic [5:0] ld;
  logic       any_ld, multi;
  // Strobes packed in priority order, most significant first.
  assign ld     = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
  assign any_ld = |ld;
  // Clearing the lowest set bit leaves something only when two or more strobes are high.
  assign multi  = (ld & (ld - 6'd1)) != 6'd0;
  assign cnt_d  = (any_ld && cnt_q != 3'd6) ? cnt_q + 3'd1 : cnt_q;
`ifdef CARD_LFSR_SHUFFLE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  last_q;
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  // Out-of-range nibbles repeat the last valid rank so the presented rank stays 1..NUM_RANKS.
  assign rank   = (lfsr_q[3:0] < NR) ? lfsr_q[3:0] + 4'd1 : last_q;
  always_ff @(posedge slow_clock or negedge resetb)
    if (!resetb) begin
      lfsr_q <= 16'hACE1;
      last_q <= 4'd1;
    end else begin
      lfsr_q <= lfsr_d;
      last_q <= rank;
    end
`else
  logic [3:0] src_q, src_d;
  assign src_d = (src_q == NR) ? 4'd1 : src_q + 4'd1;
  assign rank  = src_q;
  always_ff @(posedge slow_clock or negedge resetb)
    if (!resetb) src_q <= 4'd1;
    else src_q <= src_d;
`endif
  always_ff @(posedge slow_clock or negedge resetb)
    if (!resetb) begin
      {p1_q, p2_q, p3_q, d1_q, d2_q, d3_q} <= '0;
      cnt_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      if (load_pcard1) p1_q <= rank;
      else if (load_dcard1) d1_q <= rank;
      else if (load_pcard2) p2_q <= rank;
      else if (load_dcard2) d2_q <= rank;
      else if (load_pcard3) p3_q <= rank;
      else if (load_dcard3) d3_q <= rank;
      cnt_q <= cnt_d;
      err_q <= err_q | multi;
    end
  function automatic logic [3:0] pts(input logic [3:0] r);
    return (r >= FM) ? 4'd0 : r;
  endfunction
  // Sum peaks at 27, so one of two conditional subtractions gives mod 10.
  function automatic logic [3:0] score(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [4:0] s;
    s = 5'(pts(a)) + 5'(pts(b)) + 5'(pts(c));
    return (s >= 5'd20) ? 4'(s - 5'd20) : (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction
  assign pcard1_out     = p1_q;
  assign pcard2_out     = p2_q;
  assign pcard3_out     = p3_q;
  assign dcard1_out     = d1_q;
  assign dcard2_out     = d2_q;
  assign dcard3_out     = d3_q;
  assign pcard3         = p3_q;
  assign pscore         = score(p1_q, p2_q, p3_q);
  assign dscore         = score(d1_q, d2_q, d3_q);
  assign cards_dealt    = cnt_q;
  assign multi_load_err = err_q;
endmodule

// File: tb/tb_card_hand_datapath.sv
// tb_card_hand_datapath: randomized and directed self-checking bench against a behavioural hand model.
module tb_card_hand_datapath;
  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [5:0] ld = 6'd0;
  logic [3:0] p1, p2, p3, d1, d2, d3, pc3, ps, ds;
  logic [2:0] cd;
  logic       err;
  int         checks = 0, passes = 0;
  int         m_slot[6];
  int         m_edges, m_cnt, m_err;
  localparam int PC1 = 5, DC1 = 4, PC2 = 3, DC2 = 2, PC3 = 1, DC3 = 0;
  card_hand_datapath dut (
    .slow_clock(clk), .resetb(resetb),
    .load_pcard1(ld[PC1]), .load_pcard2(ld[PC2]), .load_pcard3(ld[PC3]),
    .load_dcard1(ld[DC1]), .load_dcard2(ld[DC2]), .load_dcard3(ld[DC3]),
    .pcard1_out(p1), .pcard2_out(p2), .pcard3_out(p3),
    .dcard1_out(d1), .dcard2_out(d2), .dcard3_out(d3),
    .pcard3(pc3), .pscore(ps), .dscore(ds),
    .cards_dealt(cd), .multi_load_err(err)
  );
  always #5 clk = ~clk;
  function automatic int pts(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction
  // Model slots are indexed by priority rank: 0 = pcard1 ... 5 = dcard3.
  always @(posedge clk or negedge resetb)
    if (!resetb) begin
      foreach (m_slot[i]) m_slot[i] = 0;
      m_edges = 0;
      m_cnt = 0;
      m_err = 0;
    end else begin
      int n;
      n = 0;
      for (int b = 0; b < 6; b++) n += ld[b];
      if (n > 1) m_err = 1;
      for (int k = 0; k < 6; k++)
        if (ld[5-k]) begin
          m_slot[k] = (m_edges % 13) + 1;
          m_cnt = (m_cnt < 6) ? m_cnt + 1 : 6;
          break;
        end
      m_edges++;
    end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk)
    if (resetb) begin
      chk("pcard1", p1, m_slot[0]);
      chk("dcard1", d1, m_slot[1]);
      chk("pcard2", p2, m_slot[2]);
      chk("dcard2", d2, m_slot[3]);
      chk("pcard3_out", p3, m_slot[4]);
      chk("dcard3", d3, m_slot[5]);
      chk("pcard3", pc3, m_slot[4]);
      chk("pscore", ps, (pts(m_slot[0]) + pts(m_slot[2]) + pts(m_slot[4])) % 10);
      chk("dscore", ds, (pts(m_slot[1]) + pts(m_slot[3]) + pts(m_slot[5])) % 10);
      chk("cards_dealt", cd, m_cnt);
      chk("multi_load_err", err, m_err);
    end
  task automatic step(input logic [5:0] v);
    ld = v;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(6'd0);
  endtask
  task automatic do_reset;
    ld = 6'd0;
    resetb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
  endtask
  initial begin
    do_reset;
    step(6'd1 << PC1); step(6'd1 << DC1); step(6'd1 << PC2); step(6'd1 << DC2);
    chk("t1 pcard1", p1, 1); chk("t1 dcard1", d1, 2); chk("t1 pcard2", p2, 3); chk("t1 dcard2", d2, 4);
    chk("t1 pscore", ps, 4); chk("t1 dscore", ds, 6); chk("t1 cards", cd, 4); chk("t1 pcard3", pc3, 0);
    do_reset;
    idle(8); step(6'd1 << PC1); idle(11); step(6'd1 << PC2);
    chk("t2 pcard1", p1, 9); chk("t2 pcard2", p2, 8); chk("t2 pscore", ps, 7);
    do_reset;
    idle(11); step(6'd1 << DC1); step(6'd1 << DC2);
    chk("t3 dcard1", d1, 12); chk("t3 dcard2", d2, 13); chk("t3 dscore face", ds, 0);
    step(6'd1 << DC3);
    chk("t3 dcard3", d3, 1); chk("t3 dscore", ds, 1);
    do_reset;
    step((6'd1 << PC1) | (6'd1 << DC1));
    chk("t4 pcard1", p1, 1); chk("t4 dcard1", d1, 0); chk("t4 err", err, 1); chk("t4 cards", cd, 1);
    idle(10);
    chk("t4 err sticky", err, 1);
    do_reset;
    for (int k = 0; k < 6; k++) step(6'd1 << (5 - k));
    chk("t5 cards pre", cd, 6);
    ld = 6'd0;
    #2 resetb = 1'b0;
    #1;
    chk("t5 pcard1", p1, 0); chk("t5 dcard3", d3, 0); chk("t5 pscore", ps, 0);
    chk("t5 dscore", ds, 0); chk("t5 cards", cd, 0); chk("t5 err", err, 0);
    @(negedge clk);
    resetb = 1'b1;
    step(6'd1 << PC1);
    chk("t5 first after release", p1, 1);
    do_reset;
    idle(12); step(6'd1 << PC1); step(6'd1 << PC2);
    chk("t6 wrap top", p1, 13); chk("t6 wrap 1", p2, 1);
    for (int k = 0; k < 7; k++) step(6'd1 << (k % 6));
    chk("t6 saturate", cd, 6);
    do_reset;
    for (int i = 0; i < 400; i++) begin
      logic [5:0] v;
      if ($urandom_range(0, 39) == 0) begin
        #2 resetb = 1'b0;
        #1 resetb = 1'b1;
      end
      v = 6'd0;
      case ($urandom_range(0, 5))
        0: v = 6'd0;
        1: v = 6'($urandom);
        default: v = 6'd1 << $urandom_range(0, 5);
      endcase
      step(v);
    end
    ld = 6'd0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
